// File: rtl/vxe_vpu_cmdq_pkg.sv
// Shared definitions for the multi-channel VPU command queue:
// control FSM encoding and thread-to-channel mapping.
package vxe_vpu_cmdq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } cmdq_state_e;

  // Channel is the low log2(nchan) bits of the thread ID; nchan is a power of 2.
  function automatic int unsigned chan_idx(input int unsigned th, input int unsigned nchan);
    return th & (nchan - 1);
  endfunction

endpackage

// File: rtl/vxe_vpu_cmdq_chan.sv
// Single-channel first-word-fall-through FIFO with synchronous flush,
// occupancy counter and full/empty flags.
module vxe_vpu_cmdq_chan #(
  parameter int unsigned DEPTH_POW2 = 4,
  parameter int unsigned W          = 56
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  srst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [W-1:0]          wdata_i,
  output logic [W-1:0]          rdata_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_POW2:0]   level_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_POW2;
  localparam int unsigned LW    = DEPTH_POW2 + 1;

  logic [DEPTH_POW2-1:0] wptr_q, rptr_q;
  logic [LW-1:0]         level_q;
  logic [W-1:0]          mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  // Pointer and occupancy tracking; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (srst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Entry storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !srst_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vxe_vpu_cmd_mqueue.sv
// Multi-channel VPU command queue: routes ingress commands by thread ID
// into NCHAN FWFT FIFOs, with enable/flush/drain control.
module vxe_vpu_cmd_mqueue
  import vxe_vpu_cmdq_pkg::*;
#(
  parameter int unsigned NCHAN      = 2,
  parameter int unsigned DEPTH_POW2 = 4,
  parameter int unsigned OP_W       = 5,
  parameter int unsigned TH_W       = 3,
  parameter int unsigned PL_W       = 48
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             i_enable,
  input  logic                             i_disable,
  input  logic                             i_drain,
  output logic                             o_busy,
  output logic [1:0]                       o_state,
  input  logic                             i_cmd_sel,
  output logic                             o_cmd_ack,
  input  logic [OP_W-1:0]                  i_cmd_op,
  input  logic [TH_W-1:0]                  i_cmd_th,
  input  logic [PL_W-1:0]                  i_cmd_pl,
  output logic [NCHAN-1:0]                 o_vld,
  input  logic [NCHAN-1:0]                 i_rd,
  output logic [NCHAN*OP_W-1:0]            o_op,
  output logic [NCHAN*TH_W-1:0]            o_th,
  output logic [NCHAN*PL_W-1:0]            o_pl,
  output logic [NCHAN*(DEPTH_POW2+1)-1:0]  o_level
);

  localparam int unsigned CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int unsigned DW   = OP_W + TH_W + PL_W;
  localparam int unsigned LW   = DEPTH_POW2 + 1;

  cmdq_state_e state_q, state_d;

  logic [CH_W-1:0] sel_ch;
  logic [NCHAN-1:0] chan_full, chan_empty, chan_push, chan_pop;
  logic [DW-1:0]    chan_rdata [NCHAN];
  logic             full_sel, flush, write_en;

  assign sel_ch   = CH_W'(chan_idx(32'(i_cmd_th), NCHAN));
  assign flush    = (state_q != ST_IDLE) && i_disable;
  assign write_en = (state_q == ST_ACTIVE) && i_cmd_sel && o_cmd_ack;
  assign o_busy   = |(~chan_empty);
  assign o_vld    = ~chan_empty;
  assign o_state  = state_q;

  // Control state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: disable beats drain; drain ends once every channel is empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_enable) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (i_disable)    state_d = ST_IDLE;
        else if (i_drain) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_disable)        state_d = ST_IDLE;
        else if (&chan_empty) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Full flag of the channel addressed by the ingress thread ID.
  always_comb begin
    full_sel = 1'b0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      if (sel_ch == CH_W'(c)) full_sel = chan_full[c];
    end
  end

  // Ingress ack: sink in IDLE, back-pressure in DRAIN.
  always_comb begin
    o_cmd_ack = 1'b0;
    case (state_q)
      ST_IDLE:   o_cmd_ack = 1'b1;
      ST_ACTIVE: o_cmd_ack = ~full_sel;
      default:   o_cmd_ack = 1'b0;
    endcase
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign chan_push[c] = write_en && (sel_ch == CH_W'(c));
    assign chan_pop[c]  = (state_q != ST_IDLE) && i_rd[c];

    vxe_vpu_cmdq_chan #(
      .DEPTH_POW2 (DEPTH_POW2),
      .W          (DW)
    ) u_chan (
      .clk     (clk),
      .nrst    (nrst),
      .srst_i  (flush),
      .push_i  (chan_push[c]),
      .pop_i   (chan_pop[c]),
      .wdata_i ({i_cmd_op, i_cmd_th, i_cmd_pl}),
      .rdata_o (chan_rdata[c]),
      .empty_o (chan_empty[c]),
      .full_o  (chan_full[c]),
      .level_o (o_level[c*LW +: LW])
    );

    assign o_op[c*OP_W +: OP_W] = chan_rdata[c][DW-1 -: OP_W];
    assign o_th[c*TH_W +: TH_W] = chan_rdata[c][PL_W +: TH_W];
    assign o_pl[c*PL_W +: PL_W] = chan_rdata[c][PL_W-1:0];
  end

endmodule

// File: tb/tb_vxe_vpu_cmd_mqueue.sv
// Directed self-checking bench for vxe_vpu_cmd_mqueue (NCHAN=2, depth 4).
module tb_vxe_vpu_cmd_mqueue;

  localparam int unsigned NCHAN = 2;
  localparam int unsigned DP    = 2;
  localparam int unsigned OP_W  = 5;
  localparam int unsigned TH_W  = 3;
  localparam int unsigned PL_W  = 48;
  localparam int unsigned LW    = DP + 1;

  logic                    clk = 1'b0;
  logic                    nrst;
  logic                    i_enable, i_disable, i_drain;
  logic                    o_busy;
  logic [1:0]              o_state;
  logic                    i_cmd_sel, o_cmd_ack;
  logic [OP_W-1:0]         i_cmd_op;
  logic [TH_W-1:0]         i_cmd_th;
  logic [PL_W-1:0]         i_cmd_pl;
  logic [NCHAN-1:0]        o_vld, i_rd;
  logic [NCHAN*OP_W-1:0]   o_op;
  logic [NCHAN*TH_W-1:0]   o_th;
  logic [NCHAN*PL_W-1:0]   o_pl;
  logic [NCHAN*LW-1:0]     o_level;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  vxe_vpu_cmd_mqueue #(
    .NCHAN      (NCHAN),
    .DEPTH_POW2 (DP),
    .OP_W       (OP_W),
    .TH_W       (TH_W),
    .PL_W       (PL_W)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .i_enable  (i_enable),
    .i_disable (i_disable),
    .i_drain   (i_drain),
    .o_busy    (o_busy),
    .o_state   (o_state),
    .i_cmd_sel (i_cmd_sel),
    .o_cmd_ack (o_cmd_ack),
    .i_cmd_op  (i_cmd_op),
    .i_cmd_th  (i_cmd_th),
    .i_cmd_pl  (i_cmd_pl),
    .o_vld     (o_vld),
    .i_rd      (i_rd),
    .o_op      (o_op),
    .o_th      (o_th),
    .o_pl      (o_pl),
    .o_level   (o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance one active edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [TH_W-1:0] th, input logic [PL_W-1:0] pl);
    i_cmd_sel = 1'b1;
    i_cmd_th  = th;
    i_cmd_op  = OP_W'(pl);
    i_cmd_pl  = pl;
    tick();
    i_cmd_sel = 1'b0;
  endtask

  // Check the head of channel c, then pop it.
  task automatic pop_chk(input int c, input logic [PL_W-1:0] pl, input string tag);
    chk({tag, "_vld"}, 64'(o_vld[c]), 64'd1);
    chk({tag, "_pl"}, 64'(o_pl[c*PL_W +: PL_W]), 64'(pl));
    i_rd[c] = 1'b1;
    tick();
    i_rd[c] = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; i_enable = 0; i_disable = 0; i_drain = 0;
    i_cmd_sel = 0; i_cmd_op = '0; i_cmd_th = '0; i_cmd_pl = '0; i_rd = '0;
    #12;
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_busy",  64'(o_busy),  64'd0);
    chk("rst_vld",   64'(o_vld),   64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_ack",   64'(o_cmd_ack), 64'd1);
    @(negedge clk); nrst = 1'b1;
    tick();

    // IDLE sinks commands without storing them.
    i_cmd_sel = 1'b1; i_cmd_pl = 48'h55;
    for (int i = 0; i < 3; i++) begin
      chk("idle_ack", 64'(o_cmd_ack), 64'd1);
      tick();
    end
    i_cmd_sel = 1'b0;
    chk("idle_busy",  64'(o_busy),  64'd0);
    chk("idle_level", 64'(o_level), 64'd0);

    // IDLE ignores drain/disable, enable moves to ACTIVE.
    i_drain = 1'b1; i_disable = 1'b1; tick(); i_drain = 0; i_disable = 0;
    chk("idle_ignore", 64'(o_state), 64'd0);
    i_enable = 1'b1; tick(); i_enable = 1'b0;
    chk("enable_state", 64'(o_state), 64'd1);

    // Fill channel 0 to full, fifth command stalls.
    for (int i = 0; i < 4; i++) begin
      i_cmd_sel = 1'b1; i_cmd_th = '0; i_cmd_pl = 48'h100 + 48'(i); #1;
      chk("fill_ack", 64'(o_cmd_ack), 64'd1);
      push(3'd0, 48'h100 + 48'(i));
    end
    i_cmd_sel = 1'b1; i_cmd_th = '0; i_cmd_pl = 48'h1FF; #1;
    chk("full_ack",   64'(o_cmd_ack), 64'd0);
    chk("full_level", 64'(o_level[0 +: LW]), 64'd4);
    i_rd[0] = 1'b1; #1;
    chk("full_pop_ack", 64'(o_cmd_ack), 64'd0);
    tick();
    i_rd[0] = 1'b0; i_cmd_sel = 1'b0;
    chk("after_pop_level", 64'(o_level[0 +: LW]), 64'd3);
    chk("after_pop_ack",   64'(o_cmd_ack), 64'd1);
    pop_chk(0, 48'h101, "fifo0a");
    pop_chk(0, 48'h102, "fifo0b");
    pop_chk(0, 48'h103, "fifo0c");
    chk("empty0_vld", 64'(o_vld), 64'd0);

    // Routing by low thread bit.
    push(3'd0, 48'hA); push(3'd1, 48'hB); push(3'd2, 48'hC); push(3'd3, 48'hD);
    chk("rt_level", 64'(o_level), 64'({3'd2, 3'd2}));
    chk("rt_th0", 64'(o_th[0 +: TH_W]), 64'd0);
    chk("rt_th1", 64'(o_th[TH_W +: TH_W]), 64'd1);
    chk("rt_op1", 64'(o_op[OP_W +: OP_W]), 64'hB);
    chk("rt_pl0", 64'(o_pl[0 +: PL_W]), 64'hA);
    chk("rt_pl1", 64'(o_pl[PL_W +: PL_W]), 64'hB);
    i_rd = 2'b11; tick(); i_rd = '0;
    chk("rt_pl0b", 64'(o_pl[0 +: PL_W]), 64'hC);
    chk("rt_pl1b", 64'(o_pl[PL_W +: PL_W]), 64'hD);
    chk("rt_th0b", 64'(o_th[0 +: TH_W]), 64'd2);
    i_rd = 2'b11; tick(); i_rd = '0;
    chk("rt_empty", 64'(o_level), 64'd0);

    // Wrap-around on channel 1 with overlapped push/pop; the pop on the
    // empty channel in the first cycle is ignored.
    i_rd[1] = 1'b1;
    push(3'd1, 48'h200);
    i_rd[1] = 1'b0;
    chk("wrap_first_lvl", 64'(o_level[LW +: LW]), 64'd1);
    for (int i = 1; i < 10; i++) begin
      chk("wrap_pl", 64'(o_pl[PL_W +: PL_W]), 64'h200 + 64'(i - 1));
      i_rd[1] = 1'b1;
      push(3'd1, 48'h200 + 48'(i));
      i_rd[1] = 1'b0;
    end
    chk("wrap_level1", 64'(o_level[LW +: LW]), 64'd1);
    pop_chk(1, 48'h209, "wrap_last");
    chk("wrap_level0", 64'(o_level), 64'd0);

    // Drain: stop accepting, empty out, then return to IDLE.
    push(3'd0, 48'h300); push(3'd2, 48'h301); push(3'd1, 48'h310);
    i_drain = 1'b1; tick(); i_drain = 1'b0;
    chk("drain_state", 64'(o_state), 64'd2);
    i_cmd_sel = 1'b1; i_cmd_th = 3'd1; #1;
    chk("drain_ack", 64'(o_cmd_ack), 64'd0);
    i_rd = 2'b11; tick(); i_rd = '0;
    i_cmd_sel = 1'b0;
    chk("drain_lvl", 64'(o_level), 64'({3'd0, 3'd1}));
    chk("drain_mid", 64'(o_state), 64'd2);
    pop_chk(0, 48'h301, "drain_last");
    chk("drain_hold", 64'(o_state), 64'd2);
    chk("drain_busy", 64'(o_busy), 64'd0);
    tick();
    chk("drain_idle", 64'(o_state), 64'd0);

    // Disable flushes and discards same-cycle push/pop.
    i_enable = 1'b1; tick(); i_enable = 1'b0;
    push(3'd0, 48'h400); push(3'd1, 48'h401); push(3'd0, 48'h402);
    chk("pre_flush_lvl", 64'(o_level), 64'({3'd1, 3'd2}));
    i_disable = 1'b1; i_cmd_sel = 1'b1; i_cmd_th = 3'd1; i_rd = 2'b01;
    tick();
    i_disable = 1'b0; i_cmd_sel = 1'b0; i_rd = '0;
    chk("flush_vld",   64'(o_vld),   64'd0);
    chk("flush_level", 64'(o_level), 64'd0);
    chk("flush_state", 64'(o_state), 64'd0);
    chk("flush_busy",  64'(o_busy),  64'd0);

    // Asynchronous reset mid-operation.
    i_enable = 1'b1; tick(); i_enable = 1'b0;
    push(3'd1, 48'h500);
    chk("pre_arst_vld", 64'(o_vld), 64'd2);
    #2 nrst = 1'b0; #1;
    chk("arst_vld",   64'(o_vld),   64'd0);
    chk("arst_state", 64'(o_state), 64'd0);
    chk("arst_level", 64'(o_level), 64'd0);
    chk("arst_ack",   64'(o_cmd_ack), 64'd1);
    @(negedge clk); nrst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vxe_vpu_cmd_mqueue.md
# vxe_vpu_cmd_mqueue

Multi-channel VPU command queue. A single ingress command port is routed by thread ID into NCHAN independent per-channel FIFOs, and each FIFO has its own first-word-fall-through dispatch port. Sits between the VxE command dispatcher and NCHAN VPU lane-group sequencers. Adds a graceful drain mode, per-channel occupancy reporting and parametrised field widths on top of the single-queue flush/enable control.

## Interface
- NCHAN, 2, channel count; power of 2, 1..8
- DEPTH_POW2, 4, per-channel FIFO depth = 2^DEPTH_POW2
- OP_W, 5, opcode width
- TH_W, 3, thread ID width; must satisfy 2^TH_W >= NCHAN
- PL_W, 48, payload width
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- i_enable  in  1  activate queue (IDLE only)
- i_disable  in  1  flush all channels, go IDLE
- i_drain  in  1  stop accepting, dispatch remaining, then go IDLE
- o_busy  out  1  any channel non-empty
- o_state  out  2  FSM state: 0 IDLE, 1 ACTIVE, 2 DRAIN
- i_cmd_sel  in  1  ingress command valid
- o_cmd_ack  out  1  ingress accept/sink
- i_cmd_op  in  OP_W  opcode
- i_cmd_th  in  TH_W  thread ID; channel = i_cmd_th[log2(NCHAN)-1:0] (channel 0 when NCHAN=1)
- i_cmd_pl  in  PL_W  payload
- o_vld  out  NCHAN  per-channel head valid
- i_rd  in  NCHAN  per-channel pop
- o_op  out  NCHAN*OP_W  per-channel head opcode, channel c at [c*OP_W +: OP_W]
- o_th  out  NCHAN*TH_W  per-channel head thread ID
- o_pl  out  NCHAN*PL_W  per-channel head payload
- o_level  out  NCHAN*(DEPTH_POW2+1)  per-channel occupancy

## Operation
- FSM states IDLE, ACTIVE, DRAIN; reset to IDLE.
- IDLE: i_enable -> ACTIVE. i_disable and i_drain are ignored.
- ACTIVE: i_disable -> IDLE with flush. Otherwise i_drain -> DRAIN. i_disable has priority over i_drain.
- DRAIN: i_disable -> IDLE with flush. Otherwise, when all channels are empty -> IDLE.
- o_cmd_ack:
  - IDLE: 1 (commands are sunk and dropped).
  - ACTIVE: ~full of the selected channel.
  - DRAIN: 0 (upstream is back-pressured).
- Write: state==ACTIVE & i_cmd_sel & o_cmd_ack pushes {op,th,pl} into the selected channel.
- Pop: state!=IDLE & i_rd[c] & o_vld[c]. i_rd[c] while o_vld[c]=0 is ignored.
- Flush: all read/write pointers and levels clear. A write or pop in the same cycle is discarded.
- o_level[c] = writes - pops, range 0..2^DEPTH_POW2. full when level == 2^DEPTH_POW2.
- Pointers are DEPTH_POW2 bits and wrap modulo depth.
- Per-channel ordering is strict FIFO. There is no ordering guarantee across channels.

## Timing
- Reset values: o_busy 0, o_state 0, o_vld 0, o_level 0, o_cmd_ack 1 (IDLE). o_op/o_th/o_pl are don't-care while o_vld=0.
- o_cmd_ack is combinational from state, i_cmd_th and full.
- Push at edge N: o_vld and data visible after edge N, i.e. latency 1 cycle.
- Head data is combinational from storage at the read pointer (FWFT). Pop at edge N presents the next entry after edge N.
- Full channel with simultaneous pop: ack stays 0; the write is not accepted that cycle.
- Empty channel with simultaneous push: the pop is ignored; o_vld rises next cycle.
- State transitions take effect at the next edge. A flush makes o_vld and o_busy 0 after that edge.
- DRAIN -> IDLE occurs on the edge after the last pop empties every channel.
- Asynchronous reset mid-operation: contents are lost and all outputs take reset values immediately.

## Structure
- Package vxe_vpu_cmdq_pkg holds the state encoding constants (ST_IDLE, ST_ACTIVE, ST_DRAIN) and the channel-index function.
- One sub-module, vxe_vpu_cmdq_chan: a single-channel FWFT FIFO with srst, level counter, full and empty. It is instantiated NCHAN times in a generate loop.
- The top level holds the FSM, ingress demux, ack mux and output packing.

## Test plan
- Reset, then IDLE with i_cmd_sel=1 for 3 cycles -> ack=1, no pushes, o_busy=0, o_level all 0.
- NCHAN=2, DEPTH_POW2=2, ACTIVE; push 5 cmds with th=0 -> first 4 acked, 5th stalls with ack=0, o_level[0]=4; one pop -> ack=1 the next cycle.
- Interleave th=0,1,2,3 with pl=0xA..0xD -> ch0 yields 0xA then 0xC, ch1 yields 0xB then 0xD, in order.
- Wrap-around: 10 push/pop pairs through depth 4 -> payload sequence intact, level returns to 0.
- Load ch0=2 and ch1=1, assert i_drain -> o_state=2, ack=0; pop all -> o_state=0 one cycle after the last pop.
- Load 3 entries, assert i_disable together with i_cmd_sel and i_rd -> after the edge o_vld=0, levels 0, o_state=0, nothing pushed.
